key_conditioner: RTL and testbench

//  Front-end input stage feeding the top-level button inputs (East/West/North/South/func_switch).

---
 rtl/key_conditioner.sv | 151 +++++++++++++++
 tb/tb_key_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and conditions push-button inputs.
// Produces clean levels, one-cycle press/release pulses and optional
// hold-to-repeat press pulses, with every key handled independently.
module key_conditioner #(
  parameter int N_KEYS       = 5,
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_W        = 25
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_raw,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic              any_held
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rpt_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RTE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  logic [CNT_W-1:0] deb_cnt      [N_KEYS];
  logic [CNT_W-1:0] deb_cnt_next [N_KEYS];
  logic [CNT_W-1:0] rpt_cnt      [N_KEYS];
  logic [CNT_W-1:0] rpt_cnt_next [N_KEYS];
  rpt_state_t       state        [N_KEYS];
  rpt_state_t       state_next   [N_KEYS];

  logic [N_KEYS-1:0] level_next;
  logic [N_KEYS-1:0] press_next;
  logic [N_KEYS-1:0] release_next;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  // Two-flop synchroniser bringing the asynchronous buttons into sysclk.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
    end
  end

  // Per-key debounce counter and repeat FSM next-state; release beats repeat.
  always_comb begin
    level_next   = keys_level;
    press_next   = '0;
    release_next = '0;
    rise         = '0;
    fall         = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      deb_cnt_next[k] = '0;
      rpt_cnt_next[k] = rpt_cnt[k];
      state_next[k]   = state[k];

      if (sync2[k] != keys_level[k]) begin
        if (deb_cnt[k] == DEB_LAST) begin
          level_next[k] = sync2[k];
        end else begin
          deb_cnt_next[k] = deb_cnt[k] + CNT_ONE;
        end
      end

      rise[k] = level_next[k] & ~keys_level[k];
      fall[k] = keys_level[k] & ~level_next[k];

      if (fall[k]) begin
        release_next[k] = 1'b1;
        state_next[k]   = RELEASED;
        rpt_cnt_next[k] = '0;
      end else begin
        case (state[k])
          RELEASED: begin
            if (rise[k]) begin
              press_next[k]   = 1'b1;
              state_next[k]   = HELD_DELAY;
              rpt_cnt_next[k] = '0;
            end
          end
          HELD_DELAY: begin
            if (!repeat_en[k]) begin
              rpt_cnt_next[k] = '0;
            end else if (rpt_cnt[k] == DLY_LAST) begin
              press_next[k]   = 1'b1;
              rpt_cnt_next[k] = '0;
              state_next[k]   = HELD_REPEAT;
            end else begin
              rpt_cnt_next[k] = rpt_cnt[k] + CNT_ONE;
            end
          end
          HELD_REPEAT: begin
            if (!repeat_en[k]) begin
              rpt_cnt_next[k] = '0;
              state_next[k]   = HELD_DELAY;
            end else if (rpt_cnt[k] == RTE_LAST) begin
              press_next[k]   = 1'b1;
              rpt_cnt_next[k] = '0;
            end else begin
              rpt_cnt_next[k] = rpt_cnt[k] + CNT_ONE;
            end
          end
          default: begin
            state_next[k]   = RELEASED;
            rpt_cnt_next[k] = '0;
          end
        endcase
      end
    end
  end

  // State, counters and registered outputs; reset silently drops held keys.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      keys_level   <= '0;
      keys_press   <= '0;
      keys_release <= '0;
      any_held     <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        deb_cnt[k] <= '0;
        rpt_cnt[k] <= '0;
        state[k]   <= RELEASED;
      end
    end else begin
      keys_level   <= level_next;
      keys_press   <= press_next;
      keys_release <= release_next;
      any_held     <= |level_next;
      for (int k = 0; k < N_KEYS; k++) begin
        deb_cnt[k] <= deb_cnt_next[k];
        rpt_cnt[k] <= rpt_cnt_next[k];
        state[k]   <= state_next[k];
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with a
// window-based debounce model and an arithmetic hold-time repeat model.
module tb_key_conditioner;

  localparam int N   = 5;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic         any;
  } exp_t;

  logic         sysclk = 1'b0;
  logic         rst;
  logic [N-1:0] keys_raw;
  logic [N-1:0] repeat_en;
  logic [N-1:0] keys_level;
  logic [N-1:0] keys_press;
  logic [N-1:0] keys_release;
  logic         any_held;

  int checks   = 0;
  int failures = 0;

  exp_t         exp_q[$];
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] s2_hist[$];
  logic [N-1:0] model_level;
  int           en_run[N];

  key_conditioner #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(5)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .keys_raw(keys_raw),
    .repeat_en(repeat_en),
    .keys_level(keys_level),
    .keys_press(keys_press),
    .keys_release(keys_release),
    .any_held(any_held)
  );

  // Free-running system clock.
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] raw, input logic [N-1:0] en, input int n);
    rst       = r;
    keys_raw  = raw;
    repeat_en = en;
    repeat (n) @(negedge sysclk);
  endtask

  // Reference model: a level flips once the last DEB synchronised samples all
  // disagree with it; repeats fire when enabled hold time hits RD + k*RR.
  always @(posedge sysclk) begin : model_proc
    exp_t         e;
    logic [N-1:0] s2_pre;
    logic         flip;
    e = '0;
    if (rst) begin
      raw_hist = {N'(0), N'(0)};
      s2_hist.delete();
      model_level = '0;
      for (int k = 0; k < N; k++) en_run[k] = 0;
    end else begin
      s2_pre = raw_hist[raw_hist.size()-2];
      s2_hist.push_back(s2_pre);
      if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
      raw_hist.push_back(keys_raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      for (int k = 0; k < N; k++) begin
        flip = (s2_hist.size() == DEB);
        foreach (s2_hist[i]) if (s2_hist[i][k] == model_level[k]) flip = 1'b0;
        if (flip) begin
          if (model_level[k]) e.rel[k] = 1'b1;
          else                e.press[k] = 1'b1;
          model_level[k] = ~model_level[k];
          en_run[k] = 0;
        end else if (model_level[k]) begin
          if (repeat_en[k]) begin
            en_run[k]++;
            if (en_run[k] >= RD && (en_run[k] - RD) % RR == 0) e.press[k] = 1'b1;
          end else begin
            en_run[k] = 0;
          end
        end
      end
      e.level = model_level;
      e.any   = |model_level;
    end
    exp_q.push_back(e);
  end

  // Monitor: pops the expectation for each edge and compares it half a cycle later.
  always @(negedge sysclk) begin : monitor_proc
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      checkOutput("keys_level",   keys_level,   e.level);
      checkOutput("keys_press",   keys_press,   e.press);
      checkOutput("keys_release", keys_release, e.rel);
      checkOutput("any_held",     N'(any_held), N'(e.any));
    end
  end

  // Directed scenarios followed by randomized traffic with occasional resets.
  initial begin
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic         r;
    applyStimulus(1'b1, 5'h1F, 5'h00, 3);
    applyStimulus(1'b0, 5'h1F, 5'h00, 6);
    checkOutput("reset_release_level", keys_level, 5'h1F);
    checkOutput("reset_release_press", keys_press, 5'h1F);
    applyStimulus(1'b0, 5'h00, 5'h00, 12);

    applyStimulus(1'b0, 5'h01, 5'h00, 3);
    applyStimulus(1'b0, 5'h00, 5'h00, 3);
    applyStimulus(1'b0, 5'h01, 5'h00, 3);
    applyStimulus(1'b0, 5'h00, 5'h00, 10);

    applyStimulus(1'b0, 5'h04, 5'h00, 20);
    applyStimulus(1'b0, 5'h00, 5'h00, 10);

    applyStimulus(1'b0, 5'h08, 5'h08, 25);
    applyStimulus(1'b0, 5'h00, 5'h08, 10);

    applyStimulus(1'b0, 5'h08, 5'h08, 17);
    applyStimulus(1'b0, 5'h08, 5'h00, 3);
    applyStimulus(1'b0, 5'h08, 5'h08, 15);
    applyStimulus(1'b0, 5'h00, 5'h08, 10);

    applyStimulus(1'b0, 5'h11, 5'h00, 12);
    applyStimulus(1'b0, 5'h01, 5'h00, 6);
    applyStimulus(1'b0, 5'h00, 5'h00, 10);

    applyStimulus(1'b0, 5'h1F, 5'h1F, 14);
    applyStimulus(1'b1, 5'h1F, 5'h1F, 2);
    applyStimulus(1'b0, 5'h1F, 5'h1F, 10);
    applyStimulus(1'b0, 5'h00, 5'h00, 10);

    raw = '0;
    en  = 5'h1F;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) raw[k] = ~raw[k];
        if ($urandom_range(0, 40) == 0) en[k] = ~en[k];
      end
      r = ($urandom_range(0, 599) == 0);
      applyStimulus(r, raw, en, 1);
    end
    applyStimulus(1'b0, 5'h00, 5'h00, 20);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
